alu_responder: RTL
==================

Name: alu_responder

Overview:
- Multi-cycle ALU that executes operations issued by the register-file command controller.
- Accepts an opcode and two operands on a req/busy handshake.
- Returns a 32-bit result `y`, zero flag `Z` and carry flag `C` with a one-cycle `valid` strobe.
- Single-cycle ops complete immediately. Shifts and multiply are iterative, so the controller must wait for `valid` instead of assuming fixed timing.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- SHAMT_W, $clog2(WIDTH), number of low `data_b` bits used as the shift amount.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- req  input  1  request; sampled only while idle
- alu_op_code  input  3  operation select
- data_a  input  WIDTH  operand A
- data_b  input  WIDTH  operand B (for shifts: shift amount in data_b[SHAMT_W-1:0])
- busy  output  1  high while an iterative op is in progress
- valid  output  1  one-cycle strobe: y/Z/C updated this cycle
- y  output  WIDTH  result, held until next completion
- Z  output  1  (y == 0) for the completed op, held
- C  output  1  ADD carry-out; SUB no-borrow (A >= B unsigned); 0 for all other ops; held

Behaviour:
- Reset: synchronous, active-low. While rst_n=0 at a rising edge:
  - state -> IDLE
  - busy=0, valid=0, y=0, Z=0, C=0
  - step counter and operand registers cleared
  - Reset mid-operation discards the op; no valid is produced.
- Opcodes:
  - 000 ADD: A+B, mod 2^WIDTH
  - 001 SUB: A-B, mod 2^WIDTH
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL: A << n, zero fill
  - 110 SRL: A >> n, logical
  - 111 MUL: low WIDTH bits of unsigned A*B
- States: IDLE, COMPUTE.
- Accept edge E0: state==IDLE and req=1. At E0 the opcode and operands are captured.
- Single-cycle ops (000-100, and 101/110 with n=0):
  - y/Z/C loaded at E0.
  - valid=1 for the cycle after E0.
  - State stays IDLE; busy is never asserted.
- Shifts with n>0:
  - IDLE->COMPUTE at E0; busy=1.
  - One bit position per edge E1..En.
  - At En: result loaded, valid=1 for one cycle, busy=0, state->IDLE.
- MUL (shift-add, one multiplier bit per edge):
  - IDLE->COMPUTE at E0.
  - Steps E1..E_WIDTH; result loaded at E_WIDTH.
  - valid=1 for one cycle after E_WIDTH, state->IDLE.
- Latency from E0 to valid:
  - single-cycle ops: 1 cycle
  - shifts: n+1 cycles
  - MUL: WIDTH+1 cycles
- Back-to-back: req may be accepted in the same cycle valid is high, since state is already IDLE. The new E0 overwrites nothing until that op completes.
- Input handling:
  - req while busy=1 is ignored; no queueing. The requester must hold req or reissue it.
  - Inputs are ignored except at E0; changes to data_a/data_b/alu_op_code during COMPUTE have no effect.
- Output hold: y, Z, C change only on completion or reset. valid is never high for two consecutive cycles from one request.
- Z is computed from the final WIDTH-bit result, including MUL truncation.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined: SLL/SRL use a single-cycle barrel shifter and behave as single-cycle ops (latency 1 for any n). busy is asserted only for MUL.
- Undefined: iterative shifts as specified above.
- Results, Z and C are identical in both builds; only timing differs.

Test Plan:
- ADD: A=0xFFFFFFFF, B=0x00000001, req 1 cycle -> next cycle valid=1, y=0x00000000, Z=1, C=1, busy never 1.
- SUB: A=5, B=5 -> y=0, Z=1, C=1. Then A=3, B=5 -> y=0xFFFFFFFE, Z=0, C=0. Issued back-to-back, req accepted in the valid cycle.
- SLL (macro off): A=0x00000001, B=4 -> busy=1 for 4 cycles, valid 5 cycles after E0, y=0x00000010.
- SLL (macro on): same inputs -> valid 1 cycle after E0, busy stays 0, same y.
- MUL: A=0x00010001, B=0x00010001 -> valid 33 cycles after E0, y=0x00020001, Z=0, C=0. A second req and operand changes during busy are ignored.
- Reset mid-op: start MUL, drive rst_n=0 at step 10 -> busy=0, valid=0, y=0, Z=0, C=0, no late valid. A following AND 0xF0F0F0F0 & 0x0F0F0F0F -> y=0, Z=1, C=0.

Source files
------------

// File: rtl/alu_responder.sv
// rtl/alu_responder.sv - multi-cycle ALU with req/busy handshake and one-cycle valid strobe
// Optional ALU_FAST_SHIFT_EN: single-cycle barrel shifts instead of one bit per cycle.
module alu_responder #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [2:0]       alu_op_code,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] y,
    output logic             Z,
    output logic             C
);
    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, COMPUTE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;     // shift work register / multiplicand
    logic [WIDTH-1:0]   b_q, b_d;     // multiplier, consumed LSB first
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               z_q, z_d;
    logic               c_q, c_d;

    logic [WIDTH:0]     sum, diff;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   mul_step;
    logic [WIDTH-1:0]   res;
    logic               carry;
    logic               done;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        y_d      = y_q;
        z_d      = z_q;
        c_d      = c_q;
        res      = '0;
        carry    = 1'b0;
        done     = 1'b0;
        sum      = {1'b0, data_a} + {1'b0, data_b};
        diff     = {1'b0, data_a} - {1'b0, data_b};
        shamt    = data_b[SHAMT_W-1:0];
        mul_step = acc_q + (b_q[0] ? a_q : '0);

        case (state_q)
            IDLE: begin
                if (req) begin
                    op_d  = alu_op_code;
                    a_d   = data_a;
                    b_d   = data_b;
                    acc_d = '0;
                    case (alu_op_code)
                        OP_ADD: begin res = sum[WIDTH-1:0];  carry = sum[WIDTH];   done = 1'b1; end
                        OP_SUB: begin res = diff[WIDTH-1:0]; carry = ~diff[WIDTH]; done = 1'b1; end
                        OP_AND: begin res = data_a & data_b; done = 1'b1; end
                        OP_OR:  begin res = data_a | data_b; done = 1'b1; end
                        OP_XOR: begin res = data_a ^ data_b; done = 1'b1; end
                        OP_SLL, OP_SRL: begin
`ifdef ALU_FAST_SHIFT_EN
                            res  = (alu_op_code == OP_SLL) ? (data_a << shamt) : (data_a >> shamt);
                            done = 1'b1;
`else
                            if (shamt == '0) begin
                                res  = data_a;
                                done = 1'b1;
                            end else begin
                                state_d = COMPUTE;
                                busy_d  = 1'b1;
                                cnt_d   = {1'b0, shamt};
                            end
`endif
                        end
                        default: begin
                            state_d = COMPUTE;
                            busy_d  = 1'b1;
                            cnt_d   = CNT_W'(WIDTH);
                        end
                    endcase
                end
            end
            COMPUTE: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_step;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    res   = mul_step;
                end else if (op_q == OP_SLL) begin
                    a_d = a_q << 1;
                    res = a_q << 1;
                end else begin
                    a_d = a_q >> 1;
                    res = a_q >> 1;
                end
                done = (cnt_q == CNT_W'(1));
            end
            default: state_d = IDLE;
        endcase

        // Completion: publish result and return to IDLE so a new req can be taken next edge
        if (done) begin
            y_d     = res;
            z_d     = (res == '0);
            c_d     = carry;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            y_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            y_q     <= y_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign y     = y_q;
    assign Z     = z_q;
    assign C     = c_q;
endmodule
